// File: rtl/rv32_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M mul/div unit.
interface rv32_muldiv_if;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] instr_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [31:0] instr_o;

  modport master (
    output start_i, flush_i, funct3_i, op_a_i, op_b_i, instr_i,
    input  busy_o, done_o, result_o, instr_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, op_a_i, op_b_i, instr_i,
    output busy_o, done_o, result_o, instr_o
  );
endinterface

// File: rtl/rv32_muldiv_unit.sv
// Multi-cycle RV32M unit: one-cycle 33x33 multiply, 32-step restoring divide
// on magnitudes with a sign fix-up cycle; divide corner cases resolve at capture.
module rv32_muldiv_unit (
  input  logic         clk_i,
  input  logic         rst_ni,
  rv32_muldiv_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] mul_a_q, mul_b_q;
  logic [31:0] acc_q, quot_q, dvsr_q, instr_q;
  logic [31:0] result_q, instr_out_q;
  logic [1:0]  f3_q;
  logic        neg_q_q, neg_r_q;
  logic [5:0]  cnt_q;

  logic        capture, load_res;
  logic [31:0] res_d;

  logic        is_div, div_sgn, div_zero, div_ovf, special;
  logic        mul_sa, mul_sb;
  logic [31:0] abs_a, abs_b, spec_res;
  logic signed [63:0] prod;
  logic [32:0] diff;
  logic [31:0] q_fix, r_fix;

  assign is_div   = bus.funct3_i[2];
  assign div_sgn  = ~bus.funct3_i[0];
  assign div_zero = (bus.op_b_i == 32'h0);
  assign div_ovf  = div_sgn && (bus.op_a_i == 32'h8000_0000) && (bus.op_b_i == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;
  assign abs_a    = (div_sgn && bus.op_a_i[31]) ? -bus.op_a_i : bus.op_a_i;
  assign abs_b    = (div_sgn && bus.op_b_i[31]) ? -bus.op_b_i : bus.op_b_i;
  assign spec_res = div_zero ? (bus.funct3_i[1] ? bus.op_a_i : 32'hFFFF_FFFF)
                             : (bus.funct3_i[1] ? 32'h0 : 32'h8000_0000);

  // MULHU zero-extends a; only MUL/MULH sign-extend b.
  assign mul_sa = (bus.funct3_i[1:0] != 2'b11) & bus.op_a_i[31];
  assign mul_sb = ~bus.funct3_i[1] & bus.op_b_i[31];

  // 33-bit operands widened to 64 bits; the low 64 bits of the product are exact.
  assign prod = $signed({{31{mul_a_q[32]}}, mul_a_q}) * $signed({{31{mul_b_q[32]}}, mul_b_q});

  // Restoring step: shift next dividend bit into the partial remainder, try subtract.
  assign diff  = {acc_q, quot_q[31]} - {1'b0, dvsr_q};
  assign q_fix = neg_q_q ? -quot_q : quot_q;
  assign r_fix = neg_r_q ? -acc_q  : acc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_res = 1'b0;
    res_d    = 32'h0;
    case (state_q)
      S_IDLE: if (bus.start_i) begin
        capture = 1'b1;
        if (!is_div) state_d = S_MUL;
        else if (special) begin
          state_d  = S_DONE;
          load_res = 1'b1;
          res_d    = spec_res;
        end else state_d = S_DIV;
      end
      S_MUL: begin
        state_d  = S_DONE;
        load_res = 1'b1;
        res_d    = (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
      end
      S_DIV: if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX: begin
        state_d  = S_DONE;
        load_res = 1'b1;
        res_d    = f3_q[1] ? r_fix : q_fix;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d  = S_IDLE;
      capture  = 1'b0;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      instr_q     <= '0;
      f3_q        <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      instr_out_q <= '0;
    end else begin
      if (capture) begin
        mul_a_q <= {mul_sa, bus.op_a_i};
        mul_b_q <= {mul_sb, bus.op_b_i};
        acc_q   <= '0;
        quot_q  <= abs_a;
        dvsr_q  <= abs_b;
        neg_q_q <= div_sgn & (bus.op_a_i[31] ^ bus.op_b_i[31]);
        neg_r_q <= div_sgn & bus.op_a_i[31];
        f3_q    <= bus.funct3_i[1:0];
        instr_q <= bus.instr_i;
        cnt_q   <= '0;
      end else if (state_q == S_DIV) begin
        cnt_q  <= cnt_q + 6'd1;
        quot_q <= {quot_q[30:0], ~diff[32]};
        acc_q  <= diff[32] ? {acc_q[30:0], quot_q[31]} : diff[31:0];
      end
      // Corner-case divides commit straight from IDLE, before instr_q is written.
      if (load_res) begin
        result_q    <= res_d;
        instr_out_q <= (state_q == S_IDLE) ? bus.instr_i : instr_q;
      end
    end
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
  assign bus.instr_o  = instr_out_q;
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Bench for rv32_muldiv_unit: arithmetic reference model plus per-cycle compare
// of busy/done/result/instr, directed test-plan cases and random operations.
module tb_rv32_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_muldiv_if bus();
  rv32_muldiv_unit dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_chk = 0;
  int n_fail = 0;
  // Model: busy over edges [m_first, m_last], done after edge m_done.
  int m_first = -1, m_last = -1, m_done = -1;
  logic [31:0] m_res = '0, m_ins = '0, hold_res = '0, hold_ins = '0;
  bit mon_en = 1'b0;
  bit eb, ed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  always @(negedge clk) if (mon_en) begin
    eb = (m_first >= 0) && (edge_cnt >= m_first) && (edge_cnt <= m_last);
    ed = (m_done >= 0) && (edge_cnt == m_done);
    if (ed) begin
      hold_res = m_res;
      hold_ins = m_ins;
    end
    check("busy", 32'(bus.busy_o), 32'(eb));
    check("done", 32'(bus.done_o), 32'(ed));
    check("result", bus.result_o, hold_res);
    check("instr", bus.instr_o, hold_ins);
  end

  // Called at a negedge with the DUT idle; returns at the first idle negedge after DONE.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ins, input bit poke, input bit has_lit,
                       input logic [31:0] lit);
    int L;
    logic [31:0] r;
    r = ref_res(f3, a, b);
    L = lat(f3, a, b);
    if (has_lit) check("model_pin", r, lit);
    bus.start_i = 1'b1; bus.funct3_i = f3; bus.op_a_i = a; bus.op_b_i = b; bus.instr_i = ins;
    m_res = r; m_ins = ins;
    m_first = edge_cnt + 1; m_last = m_first + L - 1; m_done = m_last;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      bus.start_i  = poke && (edge_cnt == m_first + 5 || edge_cnt == m_last);
      bus.funct3_i = 3'($urandom);
      bus.op_a_i   = $urandom;
      bus.op_b_i   = $urandom;
      bus.instr_i  = $urandom;
    end
    bus.start_i = 1'b0;
    if (has_lit) begin
      check("lit_result", bus.result_o, lit);
      check("lit_instr", bus.instr_o, ins);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0] f3;
    int sel;
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = '0;
    bus.op_a_i = '0; bus.op_b_i = '0; bus.instr_i = '0;
    #3;
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_done", 32'(bus.done_o), 32'h0);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_instr", bus.instr_o, 32'h0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFF, 32'h2, 32'h02B5_0533, 1'b0, 1'b1, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'h2, 32'h02B5_0533, 1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'h2, 32'h02B5_0533, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFFF, 32'h2, 32'h02B5_0533, 1'b0, 1'b1, 32'h0000_0001);
    issue(3'd4, 32'hFFFF_FFF9, 32'h2, 32'h0000_1111, 1'b1, 1'b1, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'h2, 32'h0000_2222, 1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7, 32'h0000_3333, 1'b0, 1'b1, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 32'h0000_4444, 1'b0, 1'b1, 32'd2);
    issue(3'd4, 32'h1234_5678, 32'h0, 32'h0000_5555, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(3'd5, 32'h1234_5678, 32'h0, 32'h0000_6666, 1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(3'd6, 32'h1234_5678, 32'h0, 32'h0000_7777, 1'b0, 1'b1, 32'h1234_5678);
    issue(3'd7, 32'h1234_5678, 32'h0, 32'h0000_8888, 1'b0, 1'b1, 32'h1234_5678);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_9999, 1'b0, 1'b1, 32'h8000_0000);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_AAAA, 1'b0, 1'b1, 32'h0);

    // Flush in cycle 10 of a divide, then a multiply right behind it.
    bus.start_i = 1'b1; bus.funct3_i = 3'd4; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd3;
    bus.instr_i = 32'hDEAD_0001;
    m_res = ref_res(3'd4, 32'd1000, 32'd3); m_ins = 32'hDEAD_0001;
    m_first = edge_cnt + 1; m_last = m_first + 33; m_done = m_last;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (edge_cnt < m_first + 9) @(negedge clk);
    bus.flush_i = 1'b1;
    m_last = m_first + 9; m_done = -1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 32'(bus.busy_o), 32'h0);
    check("flush_hold", bus.result_o, 32'h0);
    issue(3'd3, 32'hFFFF_FFFF, 32'h2, 32'h02B5_0533, 1'b0, 1'b1, 32'h0000_0001);

    // Flush wins over start in IDLE.
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'd0;
    bus.op_a_i = 32'd5; bus.op_b_i = 32'd5;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_prio_busy", 32'(bus.busy_o), 32'h0);

    // Asynchronous reset in cycle 5 of a divide.
    bus.start_i = 1'b1; bus.funct3_i = 3'd5; bus.op_a_i = 32'hFFFF_0000; bus.op_b_i = 32'd9;
    bus.instr_i = 32'hBEEF_0002;
    m_res = ref_res(3'd5, 32'hFFFF_0000, 32'd9); m_ins = 32'hBEEF_0002;
    m_first = edge_cnt + 1; m_last = m_first + 33; m_done = m_last;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (edge_cnt < m_first + 4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_first = -1; m_last = -1; m_done = -1; hold_res = '0; hold_ins = '0;
    #1;
    check("arst_busy", 32'(bus.busy_o), 32'h0);
    check("arst_done", 32'(bus.done_o), 32'h0);
    check("arst_result", bus.result_o, 32'h0);
    check("arst_instr", bus.instr_o, 32'h0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = -($urandom_range(1, 15));
      else b = $urandom;
      issue(f3, a, b, $urandom, ($urandom_range(0, 3) == 0), 1'b0, 32'h0);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
